// File: rtl/apb_cfg_master.sv
// Single-outstanding APB3 initiator: a valid/ready request becomes one APB transfer,
// and the result is returned on a held valid/ready response channel.
module apb_cfg_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_write_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                    state_reg,  state_next;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg,  paddr_next;
  logic [31:0]               pwdata_reg, pwdata_next;
  logic                      pwrite_reg, pwrite_next;
  logic [31:0]               rdata_reg,  rdata_next;
  logic                      err_reg,    err_next;
  logic                      tout_reg,   tout_next;
  logic [CNT_W-1:0]          cnt_reg,    cnt_next;

  always_comb begin
    state_next  = state_reg;
    paddr_next  = paddr_reg;
    pwdata_next = pwdata_reg;
    pwrite_next = pwrite_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    tout_next   = tout_reg;
    cnt_next    = cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          paddr_next  = req_addr_i;
          pwrite_next = req_write_i;
          pwdata_next = req_wdata_i;
          cnt_next    = '0;
          state_next  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_next = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          rdata_next = pwrite_reg ? 32'h0 : PRDATA;
          err_next   = PSLVERR;
          tout_next  = 1'b0;
          state_next = ST_RESP;
        end else begin
          // Saturating wait counter; the abort fires on the edge where it hits the limit.
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
          if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
            rdata_next = 32'h0;
            err_next   = 1'b1;
            tout_next  = 1'b1;
            state_next = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg  <= ST_IDLE;
      paddr_reg  <= '0;
      pwdata_reg <= 32'h0;
      pwrite_reg <= 1'b0;
      rdata_reg  <= 32'h0;
      err_reg    <= 1'b0;
      tout_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      paddr_reg  <= paddr_next;
      pwdata_reg <= pwdata_next;
      pwrite_reg <= pwrite_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
      tout_reg   <= tout_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Control outputs are pure decodes of the registered state.
  assign req_ready_o   = (state_reg == ST_IDLE);
  assign PSEL          = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
  assign PENABLE       = (state_reg == ST_ACCESS);
  assign rsp_valid_o   = (state_reg == ST_RESP);
  assign PADDR         = paddr_reg;
  assign PWDATA        = pwdata_reg;
  assign PWRITE        = pwrite_reg;
  assign rsp_rdata_o   = rdata_reg;
  assign rsp_err_o     = err_reg;
  assign rsp_timeout_o = tout_reg;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: directed and random APB transfers against a transaction-level
// model, plus a second instance with the watchdog disabled.
module tb_apb_cfg_master;

  localparam int AW = 12;
  localparam int TA = 4;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;

  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA = '0;
  logic          PWRITE, PSEL, PENABLE, PREADY = 1'b0, PSLVERR = 1'b0;

  logic          b_req_valid = 1'b0, b_req_ready;
  logic [AW-1:0] b_req_addr = '0;
  logic          b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err, b_rsp_timeout;
  logic [31:0]   b_rsp_rdata, b_PWDATA, b_PRDATA = '0;
  logic [AW-1:0] b_PADDR;
  logic          b_PWRITE, b_PSEL, b_PENABLE, b_PREADY = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  apb_cfg_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TA)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_cfg_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(0)) dut_nto (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .req_write_i(1'b0), .req_wdata_i(32'h0),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
    .rsp_err_o(b_rsp_err), .rsp_timeout_o(b_rsp_timeout),
    .PADDR(b_PADDR), .PWDATA(b_PWDATA), .PWRITE(b_PWRITE), .PSEL(b_PSEL), .PENABLE(b_PENABLE),
    .PRDATA(b_PRDATA), .PREADY(b_PREADY), .PSLVERR(1'b0)
  );

  typedef struct {
    logic [AW-1:0] addr;
    bit            wr;
    logic [31:0]   wdata;
    int            waits;
    logic [31:0]   prdata;
    bit            slverr;
    int            rdelay;
    bit            hold;
  } txn_t;

  txn_t txns[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Transaction-level expectation: a slave that stays busy TA cycles is cut off.
  function automatic void predict(input txn_t t, output int acc, output logic [31:0] rd,
                                  output logic er, output logic to);
    if (t.waits >= TA) begin
      acc = TA; rd = 32'h0; er = 1'b1; to = 1'b1;
    end else begin
      acc = t.waits + 1; rd = t.wr ? 32'h0 : t.prdata; er = t.slverr; to = 1'b0;
    end
  endfunction

  task automatic drive_req(input txn_t t);
    req_valid = 1'b1;
    req_addr  = t.addr;
    req_write = t.wr;
    req_wdata = t.wdata;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input int i);
    txn_t t;
    int acc;
    logic [31:0] er_d;
    logic er_e, er_t;
    t = txns[i];
    predict(t, acc, er_d, er_e, er_t);
    chk("req_ready_idle", req_ready, 1);
    drive_req(t);
    @(negedge HCLK);
    req_valid = 1'b0;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, t.addr);
    chk("setup_pwrite", PWRITE, t.wr);
    chk("setup_pwdata", PWDATA, t.wdata);
    chk("setup_req_ready", req_ready, 0);
    for (int k = 0; k < acc; k++) begin
      @(negedge HCLK);
      chk("access_psel", PSEL, 1);
      chk("access_penable", PENABLE, 1);
      chk("access_paddr", PADDR, t.addr);
      chk("access_pwrite", PWRITE, t.wr);
      chk("access_pwdata", PWDATA, t.wdata);
      chk("access_rsp_valid", rsp_valid, 0);
      PREADY  = (k == t.waits);
      PRDATA  = PREADY ? t.prdata : $urandom;
      PSLVERR = PREADY ? t.slverr : 1'($urandom);
    end
    @(negedge HCLK);
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    chk("resp_psel", PSEL, 0);
    chk("resp_penable", PENABLE, 0);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_rdata", rsp_rdata, er_d);
    chk("resp_err", rsp_err, er_e);
    chk("resp_timeout", rsp_timeout, er_t);
    if (t.hold && (i + 1 < txns.size())) drive_req(txns[i+1]);
    for (int d = 0; d < t.rdelay; d++) begin
      @(negedge HCLK);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, er_d);
      chk("hold_err", rsp_err, er_e);
      chk("hold_timeout", rsp_timeout, er_t);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_rdata_held", rsp_rdata, er_d);
    chk("post_err_held", rsp_err, er_e);
    $display("txn %0d %s addr=0x%03h waits=%0d rdelay=%0d -> rdata=0x%08h err=%0b timeout=%0b",
             i, t.wr ? "WR" : "RD", t.addr, t.waits, t.rdelay, rsp_rdata, rsp_err, rsp_timeout);
  endtask

  function automatic txn_t mk(input logic [AW-1:0] a, input bit w, input logic [31:0] wd,
                              input int wt, input logic [31:0] pr, input bit se,
                              input int rdl, input bit h);
    txn_t t;
    t.addr = a; t.wr = w; t.wdata = wd; t.waits = wt;
    t.prdata = pr; t.slverr = se; t.rdelay = rdl; t.hold = h;
    return t;
  endfunction

  initial begin
    int bad;
    // Reset state
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_req_ready", req_ready, 1);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Directed transfers, then a random batch
    txns.push_back(mk(12'h004, 1'b1, 32'h1000_2000, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0));
    txns.push_back(mk(12'h010, 1'b0, 32'h0,         3, 32'h0000_0401, 1'b0, 0, 1'b0));
    txns.push_back(mk(12'h020, 1'b0, 32'h0,         0, 32'h1234_5678, 1'b1, 0, 1'b0));
    txns.push_back(mk(12'h024, 1'b0, 32'h0,         0, 32'h0BAD_F00D, 1'b0, 0, 1'b0));
    txns.push_back(mk(12'h030, 1'b0, 32'h0,        50, 32'h5555_AAAA, 1'b0, 0, 1'b0));
    txns.push_back(mk(12'h040, 1'b1, 32'hA5A5_0001, 1, 32'h0,         1'b0, 5, 1'b1));
    txns.push_back(mk(12'h044, 1'b0, 32'h0,         0, 32'h7777_0002, 1'b0, 0, 1'b0));
    for (int n = 0; n < 40; n++) begin
      txns.push_back(mk(AW'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 6)),
                        $urandom, 1'($urandom), int'($urandom_range(0, 3)),
                        1'($urandom)));
    end
    for (int i = 0; i < txns.size(); i++) run_txn(i);
    req_valid = 1'b0;

    // Asynchronous reset in the middle of ACCESS
    req_valid = 1'b1; req_addr = 12'h0F0; req_write = 1'b0;
    @(negedge HCLK);
    req_valid = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("pre_rst_penable", PENABLE, 1);
    #2 HRESET = 1'b1;
    #1;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("postrst_req_ready", req_ready, 1);
    txns.push_back(mk(12'h000, 1'b0, 32'h0, 0, 32'hC0DE_0000, 1'b0, 0, 1'b0));
    run_txn(txns.size() - 1);

    // Watchdog disabled: a stalled slave keeps the transfer open indefinitely
    b_req_valid = 1'b1; b_req_addr = 12'h0A0;
    @(negedge HCLK);
    b_req_valid = 1'b0;
    chk("nto_setup_psel", b_PSEL, 1);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge HCLK);
      if (!(b_PSEL === 1'b1 && b_PENABLE === 1'b1 && b_rsp_valid === 1'b0)) bad++;
    end
    chk("nto_no_abort_cycles", bad, 0);
    b_PREADY = 1'b1; b_PRDATA = 32'hCAFE_0001;
    @(negedge HCLK);
    b_PREADY = 1'b0;
    chk("nto_rsp_valid", b_rsp_valid, 1);
    chk("nto_rsp_rdata", b_rsp_rdata, 32'hCAFE_0001);
    chk("nto_rsp_err", b_rsp_err, 0);
    chk("nto_rsp_timeout", b_rsp_timeout, 0);
    b_rsp_ready = 1'b1;
    @(negedge HCLK);
    b_rsp_ready = 1'b0;
    chk("nto_post_valid", b_rsp_valid, 0);
    chk("nto_req_ready", b_req_ready, 1);
    $display("txn nto RD addr=0x0a0 waits=1000 -> rdata=0x%08h err=%0b timeout=%0b",
             b_rsp_rdata, b_rsp_err, b_rsp_timeout);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
Single-outstanding APB3 initiator. It converts a simple valid/ready request/response interface into APB transfers toward the peripheral slaves, such as the pad-mux/boot-address/pad-config register slave. It is used by the boot/config sequencer and the debug path to program peripheral registers without a core bus master. It supports slave wait states (PREADY), error reporting (PSLVERR) and a timeout watchdog on stalled slaves.

Parameters:
APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i (4KB slave window).
TIMEOUT_CYCLES, 255, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
HCLK  in  1  clock, rising edge.
HRESET  in  1  asynchronous, active-high reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
req_addr_i  in  APB_ADDR_WIDTH  byte address.
req_write_i  in  1  1=write, 0=read.
req_wdata_i  in  32  write data.
rsp_valid_o  out  1  response valid; held until rsp_ready_i.
rsp_ready_i  in  1  response consumed.
rsp_rdata_o  out  32  read data; 0 for writes and aborted transfers.
rsp_err_o  out  1  slave PSLVERR or timeout.
rsp_timeout_o  out  1  transfer aborted by the watchdog.
PADDR  out  APB_ADDR_WIDTH  APB address.
PWDATA  out  32  APB write data.
PWRITE  out  1  APB direction.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PRDATA  in  32  APB read data.
PREADY  in  1  slave ready.
PSLVERR  in  1  slave error.

Behaviour:
- FSM states are IDLE, SETUP, ACCESS and RESP. All outputs are registered or decoded from registered state. There is no combinational path from req_* or P* inputs to any output.
- Reset values: state=IDLE; PSEL=PENABLE=PWRITE=0; PADDR=0; PWDATA=0; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; rsp_timeout_o=0; timeout counter=0.
- req_ready_o = (state==IDLE). On accept, latch addr, write and wdata into PADDR/PWRITE/PWDATA and go to SETUP.
- SETUP, exactly 1 cycle: PSEL=1, PENABLE=0. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.
  - PREADY=1: capture rsp_rdata_o = PWRITE ? 0 : PRDATA, rsp_err_o = PSLVERR, rsp_timeout_o = 0. Next cycle: PSEL=PENABLE=0, state=RESP.
  - PREADY=0: the counter increments. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 on this edge, abort. Abort captures rsp_rdata_o=0, rsp_err_o=1, rsp_timeout_o=1; next cycle PSEL=PENABLE=0, state=RESP.
  - The counter clears on entry to SETUP.
- RESP: rsp_valid_o=1, and the rsp_* fields are stable. On rsp_ready_i=1, go to IDLE with rsp_valid_o=0.
  - rsp_rdata_o, rsp_err_o and rsp_timeout_o hold their values until the next capture.
- Minimum latency: accept at edge 0, SETUP during cycle 1, ACCESS during cycle 2, rsp_valid_o high from cycle 3. Back-to-back requests are spaced 4 cycles apart when PREADY=1 and rsp_ready_i=1.
- PSLVERR is sampled only in ACCESS with PREADY=1 and ignored otherwise. PRDATA is ignored for writes.
- A req_valid_i seen outside IDLE is not accepted. The requester must hold it.
- HRESET asserted mid-transfer forces the reset values immediately and asynchronously: PSEL drops and no response is produced for the interrupted transfer.
- The timeout counter width is max(1, $clog2(TIMEOUT_CYCLES+1)). The counter saturates and never wraps.

Test Plan:
1. Write 0x1000_2000 to addr 0x004, PREADY=1 -> PSEL high for 2 cycles, PENABLE in the 2nd only, PWRITE=1, PWDATA=0x10002000; rsp_valid_o at cycle 3 with err=0, rdata=0.
2. Read addr 0x010, PREADY low 3 cycles then high with PRDATA=0x0000_0401 -> ACCESS lasts 4 cycles with stable PADDR/PENABLE; rsp_rdata_o=0x00000401, err=0.
3. Read with PREADY=1 and PSLVERR=1 -> rsp_err_o=1, rsp_timeout_o=0, rdata=PRDATA; the next request is accepted normally.
4. TIMEOUT_CYCLES=4, PREADY stuck at 0 -> PSEL deasserts after 4 ACCESS cycles; rsp_err_o=1, rsp_timeout_o=1, rdata=0. With TIMEOUT_CYCLES=0, no abort occurs after 1000 cycles.
5. rsp_ready_i held low 5 cycles while req_valid_i is held with a 2nd request -> rsp_* stable and req_ready_o=0 throughout; the 2nd request is accepted the cycle after the response handshake.
6. Assert HRESET during ACCESS -> PSEL, PENABLE and rsp_valid_o are 0 in the same cycle. After release, req_ready_o=1 and a read of 0x000 completes normally.
